// File: rtl/result_collector.sv
// result_collector: buffers worker results in a FIFO, drops DISCARD results, forwards the rest in order to the matching unit
module result_collector #(
    parameter int ADDR_WIDTH          = 10,
    parameter int COLOR_WIDTH         = 16,
    parameter int DATA_WIDTH          = 32,
    parameter int WORKER_RESULT_WIDTH = 2 + ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH,
    parameter int TOKEN_WIDTH         = WORKER_RESULT_WIDTH,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           WR_VALID,
    input  logic [WORKER_RESULT_WIDTH-1:0] WR_DATA,
    output logic                           WR_READY,
    output logic                           MU_VALID,
    output logic [TOKEN_WIDTH-1:0]         MU_DATA,
    input  logic                           MU_READY,
    output logic [15:0]                    DROP_COUNT,
    output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);
    logic [WORKER_RESULT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [WORKER_RESULT_WIDTH-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_next;
    logic push, pop, discard, load;
    // a discarded head pops regardless of the output stage, so it never blocks
    always_comb begin
        head       = mem[rd_ptr];
        discard    = head[WORKER_RESULT_WIDTH-1 -: 2] == 2'd3;
        push       = WR_VALID && WR_READY;
        pop        = (FIFO_LEVEL != '0) && (discard || !MU_VALID || MU_READY);
        load       = pop && !discard;
        level_next = FIFO_LEVEL + LW'(push) - LW'(pop);
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            WR_READY   <= 1'b0;
            MU_VALID   <= 1'b0;
            MU_DATA    <= '0;
            DROP_COUNT <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            FIFO_LEVEL <= level_next;
            WR_READY   <= level_next < DEPTH;
            if (load) begin
                MU_VALID <= 1'b1;
                MU_DATA  <= head;
            end else if (MU_READY) begin
                MU_VALID <= 1'b0;
            end
            if (pop && discard && DROP_COUNT != 16'hFFFF)
                DROP_COUNT <= DROP_COUNT + 16'd1;
        end
    end
    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= WR_DATA;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed and randomized checks of result_collector against a queue-based reference model
module tb_result_collector;
    logic        CLK, RST_N, WR_VALID, WR_READY, MU_VALID, MU_READY;
    logic [59:0] WR_DATA, MU_DATA;
    logic [15:0] DROP_COUNT;
    logic [2:0]  FIFO_LEVEL;

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;
    logic acc = 1'b0;
    logic [59:0] exp_q[$];

    result_collector dut (
        .CLK(CLK), .RST_N(RST_N), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
        .MU_VALID(MU_VALID), .MU_DATA(MU_DATA), .MU_READY(MU_READY),
        .DROP_COUNT(DROP_COUNT), .FIFO_LEVEL(FIFO_LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [59:0] rnd(input logic [1:0] opt);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {opt, r[57:0]};
    endfunction

    // one clock: sample handshakes before the edge, update the model at the edge, check hold after
    task automatic cyc();
        logic wf, mf, hold;
        logic [59:0] wd, md;
        wf = WR_VALID && WR_READY;
        wd = WR_DATA;
        mf = MU_VALID && MU_READY;
        md = MU_DATA;
        hold = MU_VALID && !MU_READY;
        @(posedge CLK);
        acc = wf;
        if (wf) begin
            if (wd[59:58] == 2'd3) exp_drop++;
            else exp_q.push_back(wd);
        end
        if (mf) begin
            if (exp_q.size() == 0) chk("spurious_token", 1, 0);
            else chk("token", md, exp_q.pop_front());
        end
        @(negedge CLK);
        if (hold) begin
            chk("hold_valid", MU_VALID, 1);
            chk("hold_data", MU_DATA, md);
        end
    endtask

    task automatic send(input logic [59:0] d);
        int n;
        WR_VALID = 1'b1;
        WR_DATA = d;
        acc = 1'b0;
        for (n = 0; n < 50 && !acc; n++) cyc();
        chk("send_accepted", acc, 1);
        WR_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        WR_VALID = 1'b0;
        MU_READY = 1'b1;
        for (n = 0; n < 100 && !(exp_q.size() == 0 && FIFO_LEVEL == 0 && !MU_VALID); n++) cyc();
        chk("drain_done", exp_q.size() == 0 && FIFO_LEVEL == 0 && !MU_VALID, 1);
        chk("drop_count", DROP_COUNT, exp_drop > 65535 ? 65535 : exp_drop);
    endtask

    initial begin
        logic [59:0] d;
        int miss;
        int lv[5] = '{1, 1, 2, 3, 4};
        int rd[5] = '{1, 1, 1, 1, 0};
        logic [1:0] opts[5] = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd2};
        RST_N = 1'b0;
        WR_VALID = 1'b0;
        WR_DATA = '0;
        MU_READY = 1'b0;
        #12;
        chk("rst_wr_ready", WR_READY, 0);
        chk("rst_mu_valid", MU_VALID, 0);
        chk("rst_mu_data", MU_DATA, 0);
        chk("rst_drop", DROP_COUNT, 0);
        chk("rst_level", FIFO_LEVEL, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        chk("ready_before_edge", WR_READY, 0);
        cyc();
        chk("ready_after_edge", WR_READY, 1);

        // single result latency
        MU_READY = 1'b1;
        d = {2'd0, 10'h005, 16'h0001, 32'hDEADBEEF};
        send(d);
        chk("lat_valid_n", MU_VALID, 0);
        chk("lat_level_n", FIFO_LEVEL, 1);
        cyc();
        chk("lat_valid_n1", MU_VALID, 1);
        chk("lat_data_n1", MU_DATA, d);
        chk("lat_level_n1", FIFO_LEVEL, 0);
        drain();

        // backpressure: stage plus four FIFO entries fill, then the next result is held
        MU_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(rnd(2'($urandom_range(0, 2))));
            chk("bp_level", FIFO_LEVEL, lv[i]);
            chk("bp_ready", WR_READY, rd[i]);
        end
        chk("bp_stage_valid", MU_VALID, 1);
        WR_VALID = 1'b1;
        WR_DATA = rnd(2'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_held", acc, 0);
            chk("bp_full_level", FIFO_LEVEL, 4);
        end
        MU_READY = 1'b1;
        miss = 0;
        while (!acc && miss < 20) begin
            cyc();
            miss++;
        end
        chk("bp_released", acc, 1);
        drain();

        // interleaved discards
        foreach (opts[i]) send(rnd(opts[i]));
        drain();
        chk("interleave_drops", DROP_COUNT, 3);

        // full-rate stream
        WR_VALID = 1'b1;
        miss = 0;
        for (int i = 0; i < 100; i++) begin
            WR_DATA = rnd(2'($urandom_range(0, 3)));
            cyc();
            if (!acc) miss++;
        end
        chk("full_rate_stalls", miss, 0);
        drain();

        // random valid/ready traffic
        for (int i = 0; i < 400; i++) begin
            MU_READY = 1'($urandom_range(0, 1));
            if (!WR_VALID || acc) begin
                WR_VALID = $urandom_range(0, 3) != 0;
                WR_DATA = rnd(2'($urandom_range(0, 3)));
            end
            cyc();
        end
        drain();

        // drop counter saturation
        WR_VALID = 1'b1;
        MU_READY = 1'b1;
        WR_DATA = rnd(2'd3);
        for (int i = 0; i < 70000 && exp_drop < 65534; i++) cyc();
        drain();
        chk("drop_fffe", DROP_COUNT, 16'hFFFE);
        for (int i = 0; i < 3; i++) send(rnd(2'd3));
        drain();
        chk("drop_sat", DROP_COUNT, 16'hFFFF);
        repeat (5) cyc();
        chk("drop_sat_stays", DROP_COUNT, 16'hFFFF);

        // asynchronous reset mid-traffic
        MU_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(rnd(2'($urandom_range(0, 2))));
        chk("pre_rst_level", FIFO_LEVEL, 3);
        chk("pre_rst_valid", MU_VALID, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_wr_ready", WR_READY, 0);
        chk("async_mu_valid", MU_VALID, 0);
        chk("async_mu_data", MU_DATA, 0);
        chk("async_drop", DROP_COUNT, 0);
        chk("async_level", FIFO_LEVEL, 0);
        exp_q.delete();
        exp_drop = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        MU_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("post_rst_no_token", MU_VALID, 0);
        end
        chk("post_rst_ready", WR_READY, 1);
        chk("post_rst_level", FIFO_LEVEL, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
